cache_tag_ctrl: RTL and testbench

- Tag/metadata controller for the direct-mapped L1 cache: 16 sets, 16-byte lines.
- Sits directly upstream of the 16x24 single-port tag SRAM, driving its csb0/web0/addr0/din0 and consuming dout0.
- Accepts CPU requests, performs the tag compare and tracks valid/dirty bits in flops.
- On a miss, sequences writeback and fill over the memory handshake, then rewrites the tag.
- Emits write-enable strobes for the sibling data array.

---
 rtl/cache_tag_ctrl_if.sv | 40 ++++
 rtl/cache_tag_ctrl.sv | 138 +++++++++++++
 tb/tb_cache_tag_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_tag_ctrl_if.sv
// Bus bundle between the cache tag controller, the CPU request port, the
// memory handshake, the data array strobes and the 16x24 tag SRAM.
interface cache_tag_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int SET_BITS   = 4,
   parameter int TAG_WIDTH  = 24
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_read;
   logic                  cpu_write;
   logic                  cpu_resp;
   logic                  data_cpu_we;
   logic                  data_fill_we;
   logic [SET_BITS-1:0]   data_set;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read;
   logic                  mem_write;
   logic                  mem_resp;
   logic                  tag_csb0;
   logic                  tag_web0;
   logic [SET_BITS-1:0]   tag_addr0;
   logic [TAG_WIDTH-1:0]  tag_din0;
   logic [TAG_WIDTH-1:0]  tag_dout0;

   // Environment side: CPU, memory and tag SRAM models
   modport master (
      output cpu_addr, cpu_read, cpu_write, mem_resp, tag_dout0,
      input  cpu_resp, data_cpu_we, data_fill_we, data_set,
      input  mem_addr, mem_read, mem_write,
      input  tag_csb0, tag_web0, tag_addr0, tag_din0
   );

   // Controller side
   modport slave (
      input  cpu_addr, cpu_read, cpu_write, mem_resp, tag_dout0,
      output cpu_resp, data_cpu_we, data_fill_we, data_set,
      output mem_addr, mem_read, mem_write,
      output tag_csb0, tag_web0, tag_addr0, tag_din0
   );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped L1 tag/metadata controller: tag compare against the tag SRAM,
// valid/dirty flops, and writeback/fill sequencing over the memory handshake.
module cache_tag_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int SET_BITS    = 4,
   parameter int OFFSET_BITS = 4,
   parameter int TAG_WIDTH   = ADDR_WIDTH - SET_BITS - OFFSET_BITS
) (
   input  logic            clk,
   input  logic            rst,
   cache_tag_ctrl_if.slave bus
);
   localparam int NSETS = 1 << SET_BITS;

   typedef enum logic [2:0] {IDLE, CMP, WB, FILL, REREAD} state_t;

   state_t                r_state;
   logic [NSETS-1:0]      r_valid;
   logic [NSETS-1:0]      r_dirty;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [TAG_WIDTH-1:0]  r_req_tag;
   logic [SET_BITS-1:0]   r_req_set;
   logic                  r_req_wr;

   logic                  w_req;
   logic                  w_hit;
   logic [SET_BITS-1:0]   w_cpu_set;
   logic                  w_unused;

   function automatic logic [ADDR_WIDTH-1:0] line_addr(
      input logic [TAG_WIDTH-1:0] tag,
      input logic [SET_BITS-1:0]  set
   );
      return {tag, set, {OFFSET_BITS{1'b0}}};
   endfunction

   assign w_req     = bus.cpu_read | bus.cpu_write;
   assign w_cpu_set = bus.cpu_addr[OFFSET_BITS +: SET_BITS];
   assign w_hit     = r_valid[r_req_set] && (bus.tag_dout0 == r_req_tag);
   assign w_unused  = ^bus.cpu_addr[OFFSET_BITS-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_dirty     <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_req) r_state <= CMP;
            CMP: begin
               if (w_hit) begin
                  if (r_req_wr) r_dirty[r_req_set] <= 1'b1;
                  r_state <= IDLE;
               end else if (r_valid[r_req_set] && r_dirty[r_req_set]) begin
                  // The SRAM output still holds the victim's tag this cycle
                  r_mem_write <= 1'b1;
                  r_mem_addr  <= line_addr(bus.tag_dout0, r_req_set);
                  r_state     <= WB;
               end else begin
                  r_mem_read <= 1'b1;
                  r_mem_addr <= line_addr(r_req_tag, r_req_set);
                  r_state    <= FILL;
               end
            end
            WB: if (bus.mem_resp) begin
               r_dirty[r_req_set] <= 1'b0;
               r_mem_write        <= 1'b0;
               r_mem_read         <= 1'b1;
               r_mem_addr         <= line_addr(r_req_tag, r_req_set);
               r_state            <= FILL;
            end
            FILL: if (bus.mem_resp) begin
               r_valid[r_req_set] <= 1'b1;
               r_dirty[r_req_set] <= 1'b0;
               r_mem_read         <= 1'b0;
               r_mem_addr         <= '0;
               r_state            <= REREAD;
            end
            REREAD: r_state <= CMP;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Request latch; write wins when both read and write are raised
   always_ff @(posedge clk) begin
      if (r_state == IDLE && w_req) begin
         r_req_tag <= bus.cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
         r_req_set <= w_cpu_set;
         r_req_wr  <= bus.cpu_write;
      end
   end

   // SRAM strobes and completion react to the same-cycle request/response
   always_comb begin
      bus.tag_csb0     = 1'b1;
      bus.tag_web0     = 1'b1;
      bus.tag_addr0    = '0;
      bus.tag_din0     = '0;
      bus.cpu_resp     = 1'b0;
      bus.data_cpu_we  = 1'b0;
      bus.data_fill_we = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: if (w_req) begin
               bus.tag_csb0  = 1'b0;
               bus.tag_addr0 = w_cpu_set;
            end
            CMP: if (w_hit) begin
               bus.cpu_resp    = 1'b1;
               bus.data_cpu_we = r_req_wr;
            end
            FILL: if (bus.mem_resp) begin
               bus.data_fill_we = 1'b1;
               bus.tag_csb0     = 1'b0;
               bus.tag_web0     = 1'b0;
               bus.tag_addr0    = r_req_set;
               bus.tag_din0     = r_req_tag;
            end
            REREAD: begin
               bus.tag_csb0  = 1'b0;
               bus.tag_addr0 = r_req_set;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_read  = r_mem_read;
   assign bus.mem_write = r_mem_write;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.data_set  = r_req_set;
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: tag SRAM and memory models plus a
// line-level cache model predicting hits, writebacks, fills and latencies.
module tb_cache_tag_ctrl;
   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   mem_lat  = 2;
   bit   stray_en = 1'b0;
   int   mem_cnt  = 0;

   cache_tag_ctrl_if bus_if ();

   cache_tag_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line-level model of the cache contents
   bit        m_valid [16];
   bit        m_dirty [16];
   bit [23:0] m_tag   [16];

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Tag SRAM: inputs captured at negedge, read data appears one negedge later
   logic [23:0] sram [16];
   initial begin
      bit       rd_pend;
      bit [3:0] rd_addr;
      rd_pend = 1'b0;
      rd_addr = '0;
      for (int i = 0; i < 16; i++) sram[i] = 24'($urandom);
      bus_if.tag_dout0 = '0;
      forever begin
         @(negedge clk);
         if (rd_pend) bus_if.tag_dout0 = sram[rd_addr];
         rd_pend = 1'b0;
         if (!bus_if.tag_csb0) begin
            if (!bus_if.tag_web0) sram[bus_if.tag_addr0] = bus_if.tag_din0;
            else begin
               rd_pend = 1'b1;
               rd_addr = bus_if.tag_addr0;
            end
         end
      end
   end

   // Memory: answers after mem_lat waiting cycles, optional stray pulses when idle
   initial begin
      bus_if.mem_resp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.mem_resp = 1'b0;
         if (!rst && (bus_if.mem_read || bus_if.mem_write)) begin
            if (mem_cnt >= mem_lat) begin
               bus_if.mem_resp = 1'b1;
               mem_cnt = 0;
            end else mem_cnt++;
         end else begin
            mem_cnt = 0;
            if (stray_en && !rst) bus_if.mem_resp = ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Entered and left at posedge+1; drives one request and scores it against the model
   task automatic run_req(input logic [31:0] addr, input bit rd, input bit wr, input bit toggle);
      bit [3:0]    set;
      bit [23:0]   tag;
      bit          exp_hit, exp_wb;
      logic [31:0] wb_addr, fill_addr;
      int k, resp_k, acc_cnt, wr_cnt, wr_k, fwe_cnt, fwe_k, cwe_cnt, first_mem_k;
      int wb_cyc, fill_cyc, wb_bad, fill_bad, both_bad, order_bad, wb_resp_k, fill_resp_k;
      logic [3:0]  wr_addr, set_at_resp;
      logic [23:0] wr_din;
      logic        cwe_at_resp;
      set       = addr[7:4];
      tag       = addr[31:8];
      exp_hit   = m_valid[set] && (m_tag[set] == tag);
      exp_wb    = !exp_hit && m_valid[set] && m_dirty[set];
      wb_addr   = {m_tag[set], set, 4'h0};
      fill_addr = {tag, set, 4'h0};
      {k, acc_cnt, wr_cnt, fwe_cnt, cwe_cnt, wb_cyc, fill_cyc} = '0;
      {wb_bad, fill_bad, both_bad, order_bad} = '0;
      {resp_k, wr_k, fwe_k, first_mem_k, wb_resp_k, fill_resp_k} = {6{-32'sd1}};
      wr_addr = '0; wr_din = '0; set_at_resp = '0; cwe_at_resp = 1'b0;
      bus_if.cpu_addr  = addr;
      bus_if.cpu_read  = rd;
      bus_if.cpu_write = wr;
      while (resp_k < 0 && k < 300) begin
         @(negedge clk);
         #1;
         if (k == 0) begin
            check_eq("req_csb", bus_if.tag_csb0, 1'b0);
            check_eq("req_web", bus_if.tag_web0, 1'b1);
            check_eq("req_taddr", bus_if.tag_addr0, set);
         end
         if (!bus_if.tag_csb0) begin
            acc_cnt++;
            if (!bus_if.tag_web0) begin
               wr_cnt++; wr_k = k; wr_addr = bus_if.tag_addr0; wr_din = bus_if.tag_din0;
            end
         end
         if (bus_if.mem_read && bus_if.mem_write) both_bad++;
         if ((bus_if.mem_read || bus_if.mem_write) && first_mem_k < 0) first_mem_k = k;
         if (bus_if.mem_write) begin
            wb_cyc++;
            if (bus_if.mem_addr !== wb_addr) wb_bad++;
            if (bus_if.mem_resp) wb_resp_k = k;
         end
         if (bus_if.mem_read) begin
            fill_cyc++;
            if (bus_if.mem_addr !== fill_addr) fill_bad++;
            if (exp_wb && wb_resp_k < 0) order_bad++;
            if (bus_if.mem_resp) fill_resp_k = k;
         end
         if (bus_if.data_fill_we) begin fwe_cnt++; fwe_k = k; end
         if (bus_if.data_cpu_we) cwe_cnt++;
         if (bus_if.cpu_resp) begin
            resp_k = k; set_at_resp = bus_if.data_set; cwe_at_resp = bus_if.data_cpu_we;
         end
         @(posedge clk);
         #1;
         k++;
         if (toggle) begin
            bus_if.cpu_read  = 1'($urandom);
            bus_if.cpu_write = 1'($urandom);
            bus_if.cpu_addr  = $urandom;
         end
      end
      bus_if.cpu_read  = 1'b0;
      bus_if.cpu_write = 1'b0;
      @(negedge clk);
      #1;
      check_eq("extra_resp", bus_if.cpu_resp, 1'b0);
      check_eq("idle_csb", bus_if.tag_csb0, 1'b1);
      @(posedge clk);
      #1;

      check_eq("resp_seen", resp_k >= 0, 1'b1);
      check_eq("resp_lat", resp_k, exp_hit ? 1 : fill_resp_k + 2);
      check_eq("wb_seen", wb_cyc > 0, exp_wb);
      check_eq("fill_seen", fill_cyc > 0, !exp_hit);
      check_eq("wb_addr", wb_bad, 0);
      check_eq("fill_addr", fill_bad, 0);
      check_eq("rw_excl", both_bad, 0);
      check_eq("wb_order", order_bad, 0);
      check_eq("tag_acc", acc_cnt, exp_hit ? 1 : 3);
      check_eq("tag_wr", wr_cnt, exp_hit ? 0 : 1);
      check_eq("fill_we", fwe_cnt, exp_hit ? 0 : 1);
      check_eq("cpu_we", cwe_cnt, wr);
      check_eq("cpu_we_resp", cwe_at_resp, wr);
      check_eq("data_set", set_at_resp, set);
      if (exp_wb) check_eq("wb_wait", wb_cyc, mem_lat + 1);
      if (!exp_hit) begin
         check_eq("mem_start", first_mem_k, 2);
         check_eq("fill_wait", fill_cyc, mem_lat + 1);
         check_eq("tag_wr_k", wr_k, fill_resp_k);
         check_eq("tag_wr_set", wr_addr, set);
         check_eq("tag_wr_din", wr_din, tag);
         check_eq("fill_we_k", fwe_k, fill_resp_k);
      end

      if (!exp_hit) begin
         m_valid[set] = 1'b1;
         m_dirty[set] = 1'b0;
         m_tag[set]   = tag;
      end
      if (wr) m_dirty[set] = 1'b1;
   endtask

   task automatic check_idle_outputs(input string pfx);
      check_eq({pfx, "_resp"}, bus_if.cpu_resp, 1'b0);
      check_eq({pfx, "_mrd"}, bus_if.mem_read, 1'b0);
      check_eq({pfx, "_mwr"}, bus_if.mem_write, 1'b0);
      check_eq({pfx, "_cwe"}, bus_if.data_cpu_we, 1'b0);
      check_eq({pfx, "_fwe"}, bus_if.data_fill_we, 1'b0);
      check_eq({pfx, "_csb"}, bus_if.tag_csb0, 1'b1);
      check_eq({pfx, "_web"}, bus_if.tag_web0, 1'b1);
      check_eq({pfx, "_taddr"}, bus_if.tag_addr0, 4'h0);
      check_eq({pfx, "_tdin"}, bus_if.tag_din0, 24'h0);
      check_eq({pfx, "_maddr"}, bus_if.mem_addr, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen_wb;
      logic [31:0] a;
      rst = 1'b1;
      bus_if.cpu_addr  = '0;
      bus_if.cpu_read  = 1'b0;
      bus_if.cpu_write = 1'b0;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_idle_outputs("rst");
      @(posedge clk);
      #1;

      // Directed sequence: cold miss, hits, write hit, dirty eviction
      mem_lat = 3;
      run_req(32'h0000_1230, 1'b1, 1'b0, 1'b0);
      run_req(32'h0000_1234, 1'b1, 1'b0, 1'b0);
      run_req(32'h0000_1238, 1'b0, 1'b1, 1'b0);
      mem_lat = 2;
      run_req(32'h00AB_C030, 1'b1, 1'b0, 1'b0);

      // Long fill with request inputs toggling underneath
      mem_lat = 20;
      run_req(32'h0000_5040, 1'b1, 1'b0, 1'b1);

      // Read and write together is a write
      mem_lat = 1;
      run_req(32'h00AB_C034, 1'b1, 1'b1, 1'b0);

      // Reset while a writeback is outstanding
      mem_lat = 10;
      seen_wb = 1'b0;
      bus_if.cpu_addr = 32'h0000_1230;
      bus_if.cpu_read = 1'b1;
      for (int k = 0; k < 20 && !seen_wb; k++) begin
         @(negedge clk);
         #1;
         seen_wb = bus_if.mem_write;
         @(posedge clk);
         #1;
      end
      check_eq("wb_reached", seen_wb, 1'b1);
      rst = 1'b1;
      bus_if.cpu_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_eq("abort_mwr", bus_if.mem_write, 1'b0);
      check_eq("abort_mrd", bus_if.mem_read, 1'b0);
      check_eq("abort_csb", bus_if.tag_csb0, 1'b1);
      check_eq("abort_resp", bus_if.cpu_resp, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      mem_lat = 2;
      run_req(32'h0000_1230, 1'b1, 1'b0, 1'b0);

      // Random traffic over a few sets and tags, with stray memory responses
      stray_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         bit rd, wr;
         a = {8'h00, 8'($urandom_range(1, 4)), 8'h00, 4'($urandom_range(0, 3)), 4'($urandom)};
         case ($urandom_range(0, 2))
            0: begin rd = 1; wr = 0; end
            1: begin rd = 0; wr = 1; end
            default: begin rd = 1; wr = 1; end
         endcase
         mem_lat = $urandom_range(0, 4);
         run_req(a, rd, wr, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      stray_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
